// File: rtl/game_sequencer_pkg.sv
// Shared types and widths for the game sequencer.
// The state encoding is visible on the o_state port.
package game_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/game_sequencer_if.sv
// Signal bundle between the sequencer and its neighbours:
// display timing, button, engine flags and engine controls.
interface game_sequencer_if #(
    parameter int UNSAFE_FRAMES_MAX = 60
) ();
    import game_seq_pkg::*;

    localparam int UNSAFE_W = $clog2(UNSAFE_FRAMES_MAX + 1);

    logic [10:0]            i_h_coord;
    logic [9:0]             i_v_coord;
    logic                   i_disp_enbl;
    logic                   i_btn_center;
    logic                   i_is_safe;
    state_t                 o_state;
    logic                   o_engine_step;
    logic                   o_engine_clear;
    logic [FRAME_CNT_W-1:0] o_frame_cnt;
    logic [UNSAFE_W-1:0]    o_unsafe_cnt;

    modport master (
        input  i_h_coord,
        input  i_v_coord,
        input  i_disp_enbl,
        input  i_btn_center,
        input  i_is_safe,
        output o_state,
        output o_engine_step,
        output o_engine_clear,
        output o_frame_cnt,
        output o_unsafe_cnt
    );

    modport slave (
        output i_h_coord,
        output i_v_coord,
        output i_disp_enbl,
        output i_btn_center,
        output i_is_safe,
        input  o_state,
        input  o_engine_step,
        input  o_engine_clear,
        input  o_frame_cnt,
        input  o_unsafe_cnt
    );

endinterface

// File: rtl/game_sequencer_debounce.sv
// Button synchroniser and debouncer with a registered press pulse.
// Only a 0->1 change of the stable level produces press_evt.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic arst,
    input  logic btn,
    output logic level,
    output logic press_evt
);

    localparam int CNT_W =
        (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             evt_q;
    logic             differ;
    logic             accept;

    assign differ = sync_q[1] ^ level_q;
    assign accept = differ && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            evt_q   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn};
            evt_q  <= accept && !level_q;
            if (!differ) begin
                cnt_q <= '0;
            end else if (accept) begin
                cnt_q   <= '0;
                level_q <= ~level_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level     = level_q;
    assign press_evt = evt_q;

endmodule

// File: rtl/game_sequencer.sv
// Game controller: frame tick, button handling, run/pause/over FSM,
// engine step/clear strobes and the unsafe-frame game-over counter.
module game_sequencer
    import game_seq_pkg::*;
#(
    parameter int SCREEN_WIDTH      = 800,
    parameter int SCREEN_HEIGHT     = 600,
    parameter int DEBOUNCE_CYCLES   = 16,
    parameter int FRAME_DIV         = 1,
    parameter int UNSAFE_FRAMES_MAX = 60
) (
    input logic              clk,
    input logic              arst,
    game_sequencer_if.master bus
);

    localparam int DIV_W =
        (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int UNSAFE_W = $clog2(UNSAFE_FRAMES_MAX + 1);

    localparam logic [DIV_W-1:0] DIV_LAST =
        DIV_W'(FRAME_DIV - 1);
    localparam logic [UNSAFE_W-1:0] UNSAFE_LAST =
        UNSAFE_W'(UNSAFE_FRAMES_MAX);
    localparam logic [10:0] H_LAST = 11'(SCREEN_WIDTH - 1);
    localparam logic [9:0]  V_LAST = 10'(SCREEN_HEIGHT - 1);

    logic btn_level;
    logic press_evt;
    logic press;
    logic frame_tick;

    state_t                 state_q, state_d;
    logic                   step_q, step_d;
    logic                   clear_q, clear_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [FRAME_CNT_W-1:0] frame_q, frame_d;
    logic [UNSAFE_W-1:0]    unsafe_q, unsafe_d;
    logic [UNSAFE_W-1:0]    unsafe_inc;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk       (clk),
        .arst      (arst),
        .btn       (bus.i_btn_center),
        .level     (btn_level),
        .press_evt (press_evt)
    );

    // press_evt fires on the edge the level rises, so both are high together
    assign press = press_evt & btn_level;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= bus.i_disp_enbl
                       && (bus.i_h_coord == H_LAST)
                       && (bus.i_v_coord == V_LAST);
        end
    end

    assign unsafe_inc = (unsafe_q == UNSAFE_LAST)
                      ? unsafe_q
                      : unsafe_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        step_d   = 1'b0;
        clear_d  = 1'b0;
        div_d    = div_q;
        frame_d  = frame_q;
        unsafe_d = unsafe_q;

        unique case (state_q)
            ST_IDLE: begin
                if (press) begin
                    state_d = ST_RUN;
                    clear_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (press) begin
                    state_d = ST_PAUSE;
                end else if (frame_tick) begin
                    if (div_q == DIV_LAST) begin
                        div_d   = '0;
                        step_d  = 1'b1;
                        frame_d = frame_q + 1'b1;
                        if (bus.i_is_safe) begin
                            unsafe_d = '0;
                        end else begin
                            unsafe_d = unsafe_inc;
                            if (unsafe_inc == UNSAFE_LAST) begin
                                state_d = ST_OVER;
                            end
                        end
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
            end
            ST_PAUSE: begin
                if (press) begin
                    state_d = ST_RUN;
                end
            end
            ST_OVER: begin
                if (press) begin
                    state_d = ST_RUN;
                    clear_d = 1'b1;
                end
            end
        endcase

        if (clear_d) begin
            frame_d  = '0;
            unsafe_d = '0;
            div_d    = '0;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q  <= ST_IDLE;
            step_q   <= 1'b0;
            clear_q  <= 1'b0;
            div_q    <= '0;
            frame_q  <= '0;
            unsafe_q <= '0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            clear_q  <= clear_d;
            div_q    <= div_d;
            frame_q  <= frame_d;
            unsafe_q <= unsafe_d;
        end
    end

    assign bus.o_state        = state_q;
    assign bus.o_engine_step  = step_q;
    assign bus.o_engine_clear = clear_q;
    assign bus.o_frame_cnt    = frame_q;
    assign bus.o_unsafe_cnt   = unsafe_q;

endmodule
